jk_mod_counter: RTL and testbench

Synchronous modulo-N up/down counter whose state bits are JK flip-flops driven through the JK excitation table: the inverse of the flip-flop's characteristic equation, mapping a desired next state back to J/K inputs. It is the generator side of our JK flip-flop primitive. It supplies decade and binary counting for the sequential-logic blocks and exposes its J/K vectors so benches can check the excitation logic directly.

---
 rtl/jk_pkg.sv | 24 ++
 rtl/jk_cell.sv | 32 +++
 rtl/jk_mod_counter.sv | 133 +++++++++++++
 tb/tb_jk_mod_counter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the JK-flip-flop based modulo counter.
//   - jk_excite : (current bit, desired next bit) -> {J, K}, don't-cares = 0
//   - jk_next   : JK characteristic equation (J, K, q) -> q'
//   - parameter-range constants used by the elaboration checks
package jk_pkg;

  localparam int MIN_WIDTH   = 1;
  localparam int MAX_WIDTH   = 16;
  localparam int MIN_MODULUS = 2;

  // Excitation table with don't-cares resolved to 0:
  //   0->0 : J=0 K=x -> 00    0->1 : J=1 K=x -> 10
  //   1->0 : J=x K=1 -> 01    1->1 : J=x K=0 -> 00
  // J and K are therefore never both high.
  function automatic logic [1:0] jk_excite(input logic q_cur, input logic q_nxt);
    return {~q_cur & q_nxt, q_cur & ~q_nxt};
  endfunction

  // Characteristic equation of a JK flip-flop.
  function automatic logic jk_next(input logic j, input logic k, input logic q_cur);
    return (j & ~q_cur) | (~k & q_cur);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: a single JK flip-flop bit.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low clear
//   j, k  - JK inputs
//   q     - registered state
//   qb    - complement of q
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= 1'b0;
    end else begin
      state_q <= jk_next(j, k, state_q);
    end
  end

  assign q  = state_q;
  assign qb = ~state_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous modulo-MODULUS up/down counter whose state bits
// are JK flip-flops driven through the excitation table.
// Parameters:
//   WIDTH   - counter width, 1..16
//   MODULUS - count range 0..MODULUS-1, 2..2**WIDTH
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low; clears q, wrap, err and forces J/K to 0
//   en     - count enable
//   up     - 1 counts up, 0 counts down
//   load   - parallel load request (overrides en/up)
//   din    - load value; values >= MODULUS are rejected
//   q      - registered count
//   j_vec  - per-bit J (combinational)
//   k_vec  - per-bit K (combinational)
//   wrap   - registered one-cycle pulse after a modulus wrap
//   err    - registered one-cycle pulse after a rejected load
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             wrap,
  output logic             err
);

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("jk_mod_counter: WIDTH out of range 1..16");
    end
    if (MODULUS < MIN_MODULUS || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS out of range 2..2**WIDTH");
    end
  endgenerate

  // MODULUS is compared at WIDTH+1 bits so that 2**WIDTH is representable;
  // the terminal count fits in WIDTH bits in every legal configuration.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] qb_vec;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             at_zero;
  logic             at_top;
  logic             wrap_d;
  logic             err_d;
  logic             wrap_q;
  logic             err_q;

  assign inc_ext = {1'b0, q_vec} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_ext = {1'b0, q_vec} - {{WIDTH{1'b0}}, 1'b1};
  // All complements high means the count is zero.
  assign at_zero = &qb_vec;
  assign at_top  = (q_vec == TOP_VAL);

  // Next-state selection; reset is handled in the cells and the flag
  // registers, and by gating J/K below.
  always_comb begin
    next_d = q_vec;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if ({1'b0, din} < MOD_EXT) begin
        next_d = din;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          next_d = '0;
          wrap_d = 1'b1;
        end else begin
          next_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          next_d = TOP_VAL;
          wrap_d = 1'b1;
        end else begin
          next_d = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] jk_pair;
      assign jk_pair     = jk_excite(q_vec[gi], next_d[gi]);
      assign j_vec[gi]   = reset & jk_pair[1];
      assign k_vec[gi]   = reset & jk_pair[0];

      jk_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .j     (j_vec[gi]),
        .k     (k_vec[gi]),
        .q     (q_vec[gi]),
        .qb    (qb_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_vec;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic [3:0] q;
  logic [3:0] j_vec;
  logic [3:0] k_vec;
  logic       wrap;
  logic       err;

  int n_checks;
  int n_fail;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .up    (up),
    .load  (load),
    .din   (din),
    .q     (q),
    .j_vec (j_vec),
    .k_vec (k_vec),
    .wrap  (wrap),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] eq, input logic ew, input logic ee);
    check_eq({tag, ".q"}, {28'd0, q}, {28'd0, eq});
    check_eq({tag, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
    check_eq({tag, ".err"}, {31'd0, err}, {31'd0, ee});
  endtask

  int mq;
  int nq;
  logic mw;
  logic me;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; din = 4'd0;

    // Reset held for 3 edges while counting is requested.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state("reset", 4'd0, 1'b0, 1'b0);
      check_eq("reset.j", {28'd0, j_vec}, 32'd0);
      check_eq("reset.k", {28'd0, k_vec}, 32'd0);
    end

    // Up count across the wrap.
    reset = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check_state("up", 4'(i % 10), (i == 10), 1'b0);
      $display("up step %0d: q=%0d wrap=%0b", i, q, wrap);
      if (i == 9) begin
        check_eq("up9.j", {28'd0, j_vec}, 32'b0000);
        check_eq("up9.k", {28'd0, k_vec}, 32'b1001);
      end
    end

    // Down count across the wrap.
    load = 1'b1; din = 4'd0;
    tick();
    check_state("load0", 4'd0, 1'b0, 1'b0);
    load = 1'b0; up = 1'b0;
    #1;
    check_eq("dn0.j", {28'd0, j_vec}, 32'b1001);
    check_eq("dn0.k", {28'd0, k_vec}, 32'b0000);
    tick(); check_state("dn9", 4'd9, 1'b1, 1'b0);
    tick(); check_state("dn8", 4'd8, 1'b0, 1'b0);
    tick(); check_state("dn7", 4'd7, 1'b0, 1'b0);

    // Load checks.
    load = 1'b1; din = 4'd5;
    tick(); check_state("load5", 4'd5, 1'b0, 1'b0);
    din = 4'd12;
    tick(); check_state("load12", 4'd5, 1'b0, 1'b1);
    load = 1'b0; en = 1'b0;
    #1;
    check_eq("hold.j", {28'd0, j_vec}, 32'd0);
    check_eq("hold.k", {28'd0, k_vec}, 32'd0);
    tick(); check_state("hold", 4'd5, 1'b0, 1'b0);
    load = 1'b1; din = 4'd7; en = 1'b1; up = 1'b1;
    tick(); check_state("load7", 4'd7, 1'b0, 1'b0);
    din = 4'd9;
    tick(); check_state("load9", 4'd9, 1'b0, 1'b0);
    load = 1'b0;
    tick(); check_state("load9wrap", 4'd0, 1'b1, 1'b0);

    // Mid-operation reset alongside a load.
    for (int i = 1; i <= 6; i++) tick();
    check_state("to6", 4'd6, 1'b0, 1'b0);
    reset = 1'b0; load = 1'b1; din = 4'd3;
    tick(); check_state("midrst", 4'd0, 1'b0, 1'b0);
    reset = 1'b1; load = 1'b0;
    tick(); check_state("resume", 4'd1, 1'b0, 1'b0);

    // Direction change at 9.
    for (int i = 2; i <= 9; i++) tick();
    check_state("to9", 4'd9, 1'b0, 1'b0);
    up = 1'b0;
    tick(); check_state("dirchg", 4'd8, 1'b0, 1'b0);

    // Random run against a behavioural model of the count rules.
    mq = 8;
    for (int i = 0; i < 300; i++) begin
      en   = 1'($urandom_range(0, 1));
      up   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      din  = 4'($urandom_range(0, 15));
      nq = mq; mw = 1'b0; me = 1'b0;
      if (load) begin
        if (int'(din) < 10) nq = int'(din);
        else me = 1'b1;
      end else if (en) begin
        if (up) begin
          nq = (mq == 9) ? 0 : mq + 1;
          mw = (mq == 9);
        end else begin
          nq = (mq == 0) ? 9 : mq - 1;
          mw = (mq == 0);
        end
      end
      #1;
      check_eq("rnd.jk", {28'd0, j_vec & k_vec}, 32'd0);
      check_eq("rnd.j", {28'd0, j_vec}, {28'd0, ~4'(mq) & 4'(nq)});
      check_eq("rnd.k", {28'd0, k_vec}, {28'd0, 4'(mq) & ~4'(nq)});
      tick();
      check_eq("rnd.range", {31'd0, (q < 4'd10)}, 32'd1);
      check_state("rnd", 4'(nq), mw, me);
      mq = nq;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
